// File: rtl/nsa_pkg.sv
// Shared constants, state encoding and a bit-level helper for the nibble serial adder.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  // FSM encoding; 2'd3 is unused and recovers to IDLE.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  // One-bit full adder, returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/fourbitadder.sv
// 4-bit ripple-carry adder built from full-adder cells.
module fourbitadder
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // Ripple the carry from bit 0 upwards.
  always_comb begin
    logic [NIBBLE_W:0] c;
    c      = '0;
    sum    = '0;
    c[0]   = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-nibble serial adder: operands accepted over valid/ready, summed one nibble per cycle
// through a single 4-bit adder (LSB nibble first), result returned over valid/ready.
// WIDTH must be a multiple of 4 and at least 8.
// Optional feature macro SUB_EN: adds in_sub, selecting A-B (out_cout=1 means no borrow).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = $clog2(NIBBLES);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
`ifdef SUB_EN
  logic               sub_q, sub_d;
`endif

  logic [NIBBLE_W-1:0] nib_a, nib_b, add_sum;
  logic                add_cout;
  logic                last_nib;

  // Select the current operand nibbles; subtraction feeds the inverted B nibble.
  always_comb begin
    nib_a    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    nib_b    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
`ifdef SUB_EN
    nib_b    = nib_b ^ {NIBBLE_W{sub_q}};
`endif
    last_nib = (idx_q == IDX_W'(NIBBLES - 1));
  end

  fourbitadder u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
`ifdef SUB_EN
          sub_d   = in_sub;
          // Two's-complement subtract: invert B and add one via the carry.
          if (in_sub) carry_d = 1'b1;
`endif
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = add_sum;
        carry_d = add_cout;
        if (last_nib) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Handshake and status outputs decoded from state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == DONE);
    out_sum   = sum_q;
    out_cout  = cout_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): directed cases plus random operands,
// expected results from plain arithmetic, checked by an independent output monitor.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
`ifdef SUB_EN
  logic             in_sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_mode = 0;  // 0 random, 1 held low, 2 held high

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               acc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: unsigned (WIDTH+1)-bit arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH:0] r;
    exp_t e;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    e.sum  = r[WIDTH-1:0];
    e.cout = r[WIDTH];
    e.acc  = 0;
    return e;
  endfunction

  // Consumer-side ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = ($urandom_range(3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: compares every presented result against the scoreboard head.
  initial begin
    logic prev_valid, prev_pop;
    prev_valid = 1'b0;
    prev_pop   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_pop   = 1'b0;
      end else begin
        if (prev_pop) begin
          check("idle_after_pop in_ready", 32'(in_ready), 32'(1));
          check("idle_after_pop out_valid", 32'(out_valid), 32'(0));
        end
        prev_pop = 1'b0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got sum 0x%0h, want no result", out_sum);
          end else begin
            check("out_sum", 32'(out_sum), 32'(sb[0].sum));
            check("out_cout", 32'(out_cout), 32'(sb[0].cout));
            check("in_ready_in_done", 32'(in_ready), 32'(0));
            check("busy_in_done", 32'(busy), 32'(1));
            if (!prev_valid) check("latency", 32'(cyc - sb[0].acc), 32'(NIBBLES));
            if (out_ready) begin
              void'(sb.pop_front());
              prev_pop = 1'b1;
            end
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout, want event", name);
  endtask

  // All driver tasks start and end at #1 after a rising edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout("wait_in_ready");
    in_a = a;
    in_b = b;
    in_cin = cin;
`ifdef SUB_EN
    in_sub = sub;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Operand inputs are don't-care once captured.
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    e = model(a, b, cin, sub);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) timeout("wait_result");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'(1));
    check("reset out_valid", 32'(out_valid), 32'(0));
    check("reset out_sum", 32'(out_sum), 32'(0));
    check("reset out_cout", 32'(out_cout), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    @(posedge clk); #1;

    ready_mode = 2;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done();
    issue(16'h000F, 16'h0001, 1'b1, 1'b0);
    wait_done();

    // Backpressure with stray input pulses.
    ready_mode = 1;
    issue(16'hABCD, 16'h1357, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) timeout("wait_out_valid");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1 || i == 3);
      in_a = WIDTH'($urandom);
      in_b = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("held out_valid", 32'(out_valid), 32'(1));
    ready_mode = 2;
    wait_done();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no stray capture busy", 32'(busy), 32'(0));
    end

    // Reset in the middle of CALC (idx=2).
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort in_ready", 32'(in_ready), 32'(1));
    check("abort out_valid", 32'(out_valid), 32'(0));
    check("abort busy", 32'(busy), 32'(0));
    check("abort out_sum", 32'(out_sum), 32'(0));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done();

`ifdef SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done();
`endif

    // Random operands under random backpressure.
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      logic s;
`ifdef SUB_EN
      s = 1'($urandom_range(1));
`else
      s = 1'b0;
`endif
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(1)), s);
    end
    wait_done();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
